reg_commit_sequencer: RTL and testbench

REG_COMMIT_SEQUENCER -- requirements
Module: reg_commit_sequencer

---
 rtl/reg_commit_sequencer.sv | 108 ++++++++++
 tb/tb_reg_commit_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_commit_sequencer.sv
// Commit-write sequencer: buffers ROB commit writes in a small circular FIFO,
// drains one register-file write per cycle and answers pending-write lookups.
`ifndef ROB_BIT
`define ROB_BIT 4
`endif

module reg_commit_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ROB_BIT = `ROB_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg_id,
  input  logic [31:0]              in_val,
  input  logic [ROB_BIT-1:0]       in_rob_id,
  output logic [4:0]               set_reg_id,
  output logic [31:0]              set_val,
  output logic [ROB_BIT-1:0]       set_reg_on_rob_id,
  input  logic [4:0]               query_reg_id,
  output logic                     query_hit,
  output logic [31:0]              query_val,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]         reg_id;
    logic [31:0]        val;
    logic [ROB_BIT-1:0] rob_id;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] q_idx;
  logic          enq;
  logic          deq;

  always_comb begin
    in_ready = (count_q != FULL) && !rst_in;
    // Writes to x0 are accepted handshake-wise but never stored.
    enq      = in_valid && in_ready && rdy_in && (in_reg_id != 5'd0);
    deq      = (count_q != '0) && rdy_in && !rob_clear && !rst_in;
    head_d   = head_q + AW'(deq);
    tail_d   = tail_q + AW'(enq);
    count_d  = count_q + CW'(enq) - CW'(deq);
  end

  always_comb begin
    set_reg_id        = '0;
    set_val           = '0;
    set_reg_on_rob_id = '0;
    if (deq) begin
      set_reg_id        = mem_q[head_q].reg_id;
      set_val           = mem_q[head_q].val;
      set_reg_on_rob_id = mem_q[head_q].rob_id;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest write.
  always_comb begin
    query_hit = 1'b0;
    query_val = '0;
    q_idx     = '0;
    if (!rst_in && (query_reg_id != 5'd0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_idx = head_q + AW'(i);
        if ((CW'(i) < count_q) && (mem_q[q_idx].reg_id == query_reg_id)) begin
          query_hit = 1'b1;
          query_val = mem_q[q_idx].val;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so
  // stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      mem_q[tail_q] <= '{reg_id: in_reg_id, val: in_val, rob_id: in_rob_id};
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_commit_sequencer.sv
// Self-checking bench for reg_commit_sequencer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_reg_commit_sequencer;

  localparam int DEPTH = 4;
  localparam int RB    = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rob_clear, in_valid, in_ready;
  logic [4:0]    in_reg_id, set_reg_id, query_reg_id;
  logic [31:0]   in_val, set_val, query_val;
  logic [RB-1:0] in_rob_id, set_reg_on_rob_id;
  logic          query_hit;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]    r;
    logic [31:0]   v;
    logic [RB-1:0] b;
  } ent_t;

  ent_t mq[$];

  reg_commit_sequencer #(.DEPTH(DEPTH), .ROB_BIT(RB)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rob_clear         (rob_clear),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_reg_id         (in_reg_id),
    .in_val            (in_val),
    .in_rob_id         (in_rob_id),
    .set_reg_id        (set_reg_id),
    .set_val           (set_val),
    .set_reg_on_rob_id (set_reg_on_rob_id),
    .query_reg_id      (query_reg_id),
    .query_hit         (query_hit),
    .query_val         (query_val),
    .count             (count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, then compare every output against the model.
  task automatic drive(input logic r, input logic y, input logic c, input logic v,
                       input logic [4:0] rid, input logic [31:0] val,
                       input logic [RB-1:0] rob, input logic [4:0] qid);
    logic          e_rdy, e_hit;
    logic [4:0]    e_id;
    logic [31:0]   e_val, e_qv;
    logic [RB-1:0] e_rob;
    rst_in = r; rdy_in = y; rob_clear = c; in_valid = v;
    in_reg_id = rid; in_val = val; in_rob_id = rob; query_reg_id = qid;
    #1;
    e_rdy = (mq.size() != DEPTH) && !r;
    e_id = '0; e_val = '0; e_rob = '0;
    if (!r && y && !c && mq.size() != 0) begin
      e_id = mq[0].r; e_val = mq[0].v; e_rob = mq[0].b;
    end
    e_hit = 1'b0; e_qv = '0;
    if (!r && qid != 0)
      foreach (mq[i]) if (mq[i].r == qid) begin e_hit = 1'b1; e_qv = mq[i].v; end
    check("in_ready", 32'(in_ready), 32'(e_rdy));
    check("set_reg_id", 32'(set_reg_id), 32'(e_id));
    check("set_val", set_val, e_val);
    check("set_rob", 32'(set_reg_on_rob_id), 32'(e_rob));
    check("query_hit", 32'(query_hit), 32'(e_hit));
    check("query_val", query_val, e_qv);
    check("count", 32'(count), 32'(mq.size()));
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic acc, drn;
    ent_t e;
    acc = in_valid && (mq.size() != DEPTH) && !rst_in && rdy_in;
    drn = !rst_in && rdy_in && !rob_clear && (mq.size() != 0);
    e = '{r: in_reg_id, v: in_val, b: in_rob_id};
    @(posedge clk_in);
    if (rst_in) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc && e.r != 0) mq.push_back(e);
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input logic c);
    drive(1'b0, 1'b1, c, 1'b0, 5'd0, 32'd0, '0, 5'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; in_valid = 1'b0;
    in_reg_id = '0; in_val = '0; in_rob_id = '0; query_reg_id = '0;
    @(negedge clk_in);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1, 4'd1, 5'd3); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 5'd0); tick();
    idle(1'b0);
    check("rst_count", 32'(count), 32'd0);
    tick();

    // Single write
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 5'd0); tick();
    idle(1'b0);
    check("single_id", 32'(set_reg_id), 32'd5);
    check("single_val", set_val, 32'hDEADBEEF);
    check("single_rob", 32'(set_reg_on_rob_id), 32'd3);
    tick();
    idle(1'b0);
    check("single_after_id", 32'(set_reg_id), 32'd0);
    check("single_after_cnt", 32'(count), 32'd0);
    tick();

    // Full / backpressure with the drain held
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5'(i + 1), 32'(100 + i), 4'(i), 5'd0);
      if (i == 4) begin
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_cnt", 32'(count), 32'd4);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check("full_order", 32'(set_reg_id), 32'(i + 1));
      tick();
    end
    idle(1'b0); tick();

    // x0 drop and pointer wrap under continuous drain
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hBAD, 4'd9, 5'd0); tick();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 32'(200 + i), 4'(i), 5'd0);
      if (i > 1) check("wrap_order", 32'(set_reg_id), 32'(i - 1));
      else       check("x0_drop", 32'(set_reg_id), 32'd0);
      tick();
    end
    idle(1'b0);
    check("wrap_last", 32'(set_reg_id), 32'd6);
    tick();

    // Youngest-match query
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h11, 4'd1, 5'd7);
    check("q_no_bypass", 32'(query_hit), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h22, 4'd2, 5'd7);
    check("q_old_val", query_val, 32'h11);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'd0, 5'd7);
    check("q_hit", 32'(query_hit), 32'd1);
    check("q_val", query_val, 32'h22);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 4'd0, 5'd0);
    check("q_zero", 32'(query_hit), 32'd0);
    for (int i = 0; i < 3; i++) begin idle(1'b0); tick(); end

    // Pause then flush with two entries held
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 4'd4, 5'd0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'hAA, 4'd5, 5'd0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 3), (i == 3), 1'b0, 5'd0, 32'h0, 4'd0, 5'd10);
      check("pause_id", 32'(set_reg_id), 32'd0);
      check("pause_cnt", 32'(count), 32'd2);
      tick();
    end
    idle(1'b0); check("pause_out0", 32'(set_reg_id), 32'd9); tick();
    idle(1'b0); check("pause_out1", 32'(set_reg_id), 32'd10); tick();

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5'(20 + i), 32'(300 + i), 4'(i), 5'd0); tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd21, 32'h5, 4'd1, 5'd21);
    check("rst_mid_id", 32'(set_reg_id), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("rst_no_stale", 32'(set_reg_id), 32'd0);
      check("rst_cnt", 32'(count), 32'd0);
      tick();
    end

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), $urandom(), RB'($urandom()),
            5'($urandom_range(0, 7)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
